// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: elastic stage state encoding and the
// per-stage payload/control widths used when instantiating lc3b_pipe_stage.
package lc3b_types;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int IF_ID_DATA_W  = 32;
    localparam int IF_ID_CTRL_W  = 4;
    localparam int ID_EX_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_DATA_W = 64;
    localparam int EX_MEM_CTRL_W = 12;
    localparam int MEM_WB_DATA_W = 48;
    localparam int MEM_WB_CTRL_W = 6;
    localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/lc3b_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module lc3b_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lc3b_pipe_stage.sv
// Elastic valid/ready pipeline stage with flush, ctrl zeroing on bubbles and
// stall statistics. Define PIPE_STAGE_SKID_EN for the 2-entry registered-ready skid.
//   state    | meaning
//   PS_EMPTY | no valid entry, out_ctrl held at 0
//   PS_ONE   | main register holds the head entry
//   PS_FULL  | main and skid both hold entries, in_ready low (skid build only)
module lc3b_pipe_stage
    import lc3b_types::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       r_state;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic              w_in_fire;
    logic              w_out_fire;

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_ctrl   = r_ctrl;
    assign w_out_fire = r_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_in_ready;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    assign in_ready  = r_in_ready;
    assign w_in_fire = in_valid & r_in_ready;

    // in_ready is the registered image of (next state != PS_FULL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PS_EMPTY;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_ctrl      <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_in_ready  <= 1'b0;
        end else if (flush) begin
            r_state    <= PS_EMPTY;
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= 1'b1;
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= PS_ONE;
                        r_valid <= 1'b1;
                        r_data  <= in_data;
                        r_ctrl  <= in_ctrl;
                    end
                end
                PS_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_data <= in_data;
                        r_ctrl <= in_ctrl;
                    end else if (w_in_fire) begin
                        r_state     <= PS_FULL;
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_in_ready  <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state <= PS_EMPTY;
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end
                end
                PS_FULL: begin
                    if (w_out_fire) begin
                        r_state <= PS_ONE;
                        r_data  <= r_skid_data;
                        r_ctrl  <= r_skid_ctrl;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= PS_EMPTY;
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end
`else
    logic w_in_ready;

    assign w_in_ready = !r_valid | out_ready;
    assign in_ready   = w_in_ready;
    assign w_in_fire  = in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PS_EMPTY;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_state <= PS_EMPTY;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= PS_ONE;
                        r_valid <= 1'b1;
                        r_data  <= in_data;
                        r_ctrl  <= in_ctrl;
                    end
                end
                default: begin
                    if (w_in_fire) begin
                        r_data <= in_data;
                        r_ctrl <= in_ctrl;
                    end else if (w_out_fire) begin
                        r_state <= PS_EMPTY;
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end
                end
            endcase
        end
    end
`endif

    lc3b_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_valid & ~out_ready),
        .clr   (clr_stats),
        .count (stall_cnt)
    );

endmodule
